// File: rtl/uart_receiver.sv
// 8N1 UART receive path: synchronises UART_RX, frames start/data/stop on a 16x tick, holds each byte until acknowledged.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority voting on every bit decision.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       baud16_tick,
  input  logic       UART_RX,
  input  logic       RX_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_FERR,
  output logic       RX_OVERRUN
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CENTRE_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] EARLY_CNT  = CNT_W'(OVERSAMPLE / 2 - 2);
  localparam logic [CNT_W-1:0] LATE_CNT   = CNT_W'(OVERSAMPLE / 2);
`endif

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;
  logic                   rx_prev_reg;
  logic                   fall_edge;

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] tick_cnt_reg, tick_cnt_next, tick_cnt_inc;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;

  logic [7:0] data_reg;
  logic       status_reg;
  logic       ferr_reg;
  logic       overrun_reg;

  logic start_pt;
  logic bit_pt;
  logic bit_val;
  logic deliver;
  logic ferr_set;

  // Synchroniser flops reset to the idle (high) line level so reset never fakes a start edge.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync_reg    <= '1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], UART_RX};
      rx_prev_reg <= rx_s;
    end
  end

  assign rx_s         = sync_reg[SYNC_STAGES-1];
  assign fall_edge    = rx_prev_reg & ~rx_s;
  assign tick_cnt_inc = (tick_cnt_reg == LAST_CNT) ? '0 : tick_cnt_reg + 1'b1;

`ifdef UART_RX_MAJORITY_EN
  // Votes at centre-1 and centre are held; the centre+1 sample completes the 2-of-3 decision.
  logic [1:0] vote_reg;
  logic       in_frame;

  assign in_frame = (state_reg == ST_START) || (state_reg == ST_DATA) || (state_reg == ST_STOP);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      vote_reg <= '0;
    end else if (baud16_tick && in_frame) begin
      if (tick_cnt_reg == EARLY_CNT)  vote_reg[1] <= rx_s;
      if (tick_cnt_reg == CENTRE_CNT) vote_reg[0] <= rx_s;
    end
  end

  assign start_pt = baud16_tick && (tick_cnt_reg == LATE_CNT);
  assign bit_pt   = baud16_tick && (tick_cnt_reg == LATE_CNT);
  assign bit_val  = (vote_reg[1] & vote_reg[0]) | (vote_reg[1] & rx_s) | (vote_reg[0] & rx_s);
`else
  assign start_pt = baud16_tick && (tick_cnt_reg == CENTRE_CNT);
  assign bit_pt   = baud16_tick && (tick_cnt_reg == LAST_CNT);
  assign bit_val  = rx_s;
`endif

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    deliver       = 1'b0;
    ferr_set      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (fall_edge) begin
          tick_cnt_next = '0;
          state_next    = ST_START;
        end
      end
      ST_START: begin
        if (baud16_tick) begin
          tick_cnt_next = tick_cnt_inc;
          if (start_pt) begin
            if (!bit_val) begin
              bit_idx_next = 3'd0;
              state_next   = ST_DATA;
`ifndef UART_RX_MAJORITY_EN
              tick_cnt_next = '0;
`endif
            end else begin
              state_next = ST_IDLE;
            end
          end
        end
      end
      ST_DATA: begin
        if (baud16_tick) begin
          tick_cnt_next = tick_cnt_inc;
          if (bit_pt) begin
            shift_next[bit_idx_reg] = bit_val;
            bit_idx_next            = bit_idx_reg + 3'd1;
            if (bit_idx_reg == 3'd7) state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (baud16_tick) begin
          tick_cnt_next = tick_cnt_inc;
          if (bit_pt) begin
            if (bit_val) begin
              deliver    = 1'b1;
              state_next = ST_IDLE;
            end else begin
              ferr_set   = 1'b1;
              state_next = ST_BREAK;
            end
          end
        end
      end
      // A held-low line must return high before another start edge can be armed.
      ST_BREAK: begin
        if (rx_s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      bit_idx_reg  <= 3'd0;
      shift_reg    <= 8'h00;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
    end
  end

  // A delivery takes priority over an acknowledge landing on the same cycle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      data_reg    <= 8'h00;
      status_reg  <= 1'b0;
      ferr_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      ferr_reg <= ferr_set;
      if (deliver) begin
        data_reg   <= shift_reg;
        status_reg <= 1'b1;
        if (status_reg && !RX_ACK) overrun_reg <= 1'b1;
      end else if (RX_ACK) begin
        status_reg <= 1'b0;
      end
    end
  end

  assign RX_DATA    = data_reg;
  assign RX_STATUS  = status_reg;
  assign RX_FERR    = ferr_reg;
  assign RX_OVERRUN = overrun_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: drives 8N1 frames on a divided tick and checks deliveries against a byte scoreboard.
module tb_uart_receiver;

  localparam int TICK_DIV = 4;
  localparam int OS       = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int DELIVER_TICK = OS / 2 + 1 + 9 * OS;
`else
  localparam int DELIVER_TICK = OS / 2 + 9 * OS;
`endif

  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       baud16_tick = 1'b0;
  logic       UART_RX = 1'b1;
  logic       RX_ACK = 1'b0;
  logic [7:0] RX_DATA;
  logic       RX_STATUS;
  logic       RX_FERR;
  logic       RX_OVERRUN;

  uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .baud16_tick (baud16_tick),
    .UART_RX     (UART_RX),
    .RX_ACK      (RX_ACK),
    .RX_DATA     (RX_DATA),
    .RX_STATUS   (RX_STATUS),
    .RX_FERR     (RX_FERR),
    .RX_OVERRUN  (RX_OVERRUN)
  );

  always #5 sysclk = ~sysclk;

  // Tick is high for the cycle preceding every TICK_DIV-th rising edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge sysclk);
      #1;
      div = (div + 1) % TICK_DIV;
      baud16_tick = (div == TICK_DIV - 1);
    end
  end

  int unsigned cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  logic [7:0]  sb_q[$];
  int          n_assert = 0;
  int          n_fail = 0;
  int          ferr_count = 0;
  int          deliv_count = 0;
  int unsigned last_deliv_cyc = 0;
  int unsigned start_cyc = 0;
  logic        prev_status = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Delivery monitor: a rising RX_STATUS or a changed RX_DATA is one delivered byte.
  always @(negedge sysclk) begin
    if (!reset && ((RX_STATUS && !prev_status) || (RX_DATA !== prev_data))) begin
      logic [7:0] exp_byte;
      check("sb_pending", {31'b0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        exp_byte = sb_q.pop_front();
        check("rx_data_delivered", {24'b0, RX_DATA}, {24'b0, exp_byte});
        $display("delivered byte %02h (expected %02h) at cycle %0d", RX_DATA, exp_byte, cyc);
      end
      last_deliv_cyc <= cyc;
      deliv_count    <= deliv_count + 1;
    end
    if (!reset && RX_FERR) ferr_count <= ferr_count + 1;
    prev_status <= RX_STATUS;
    prev_data   <= RX_DATA;
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk);
      while (baud16_tick !== 1'b1) @(posedge sysclk);
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_bit, input bit align);
    if (align) wait_ticks(1);
    start_cyc = cyc;
    $display("send frame %02h stop=%0b spike_bit=%0d", d, stop, spike_bit);
    UART_RX = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      if (i == spike_bit) begin
        wait_ticks(OS / 2 - 1);
        UART_RX = 1'b0;
        wait_ticks(1);
        UART_RX = d[i];
        wait_ticks(OS / 2);
      end else begin
        wait_ticks(OS);
      end
    end
    UART_RX = stop;
    wait_ticks(OS);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, {24'b0, RX_DATA}, 32'h00);
    check({tag, "_status"}, {31'b0, RX_STATUS}, 32'd0);
    check({tag, "_ferr"}, {31'b0, RX_FERR}, 32'd0);
    check({tag, "_overrun"}, {31'b0, RX_OVERRUN}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge sysclk);
    #1 reset = 1'b1;
    repeat (2) @(posedge sysclk);
    #1;
    check_reset_values(tag);
    reset = 1'b0;
  endtask

  task automatic ack_pulse();
    @(posedge sysclk);
    #1 RX_ACK = 1'b1;
    check("status_before_ack", {31'b0, RX_STATUS}, 32'd1);
    @(posedge sysclk);
    #1 RX_ACK = 1'b0;
    check("status_after_ack", {31'b0, RX_STATUS}, 32'd0);
  endtask

  task automatic ack_on_delivery();
    wait_ticks(DELIVER_TICK - 1);
    wait (baud16_tick === 1'b1);
    RX_ACK = 1'b1;
    @(posedge sysclk);
    #1 RX_ACK = 1'b0;
  endtask

  initial begin
    int deliv_before;

    // Power-on reset
    repeat (3) @(posedge sysclk);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    // Single byte, latency, acknowledge
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, 1'b1);
    check("a5_sb_empty", sb_q.size(), 32'd0);
    check("a5_latency", last_deliv_cyc - start_cyc, TICK_DIV * DELIVER_TICK);
    check("a5_data", {24'b0, RX_DATA}, 32'hA5);
    check("a5_status", {31'b0, RX_STATUS}, 32'd1);
    ack_pulse();
    check("a5_ferr_count", ferr_count, 32'd0);
    check("a5_overrun", {31'b0, RX_OVERRUN}, 32'd0);

    // Short low glitch must be rejected at the start-bit check
    deliv_before = deliv_count;
    wait_ticks(1);
    UART_RX = 1'b0;
    wait_ticks(4);
    UART_RX = 1'b1;
    wait_ticks(24);
    check("glitch_status", {31'b0, RX_STATUS}, 32'd0);
    check("glitch_ferr_count", ferr_count, 32'd0);
    check("glitch_no_delivery", deliv_count, deliv_before);

    // Framing error followed by a held-low break
    send_frame(8'h3C, 1'b0, -1, 1'b1);
    wait_ticks(40);
    UART_RX = 1'b1;
    wait_ticks(4);
    check("ferr_count", ferr_count, 32'd1);
    check("ferr_status", {31'b0, RX_STATUS}, 32'd0);
    check("ferr_data_kept", {24'b0, RX_DATA}, 32'hA5);
    sb_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1, 1'b1);
    check("r81_sb_empty", sb_q.size(), 32'd0);
    check("r81_data", {24'b0, RX_DATA}, 32'h81);
    ack_pulse();

    // Back-to-back without acknowledge: overrun
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1, 1'b1);
    send_frame(8'h22, 1'b1, -1, 1'b0);
    wait_ticks(2);
    check("ovr_sb_empty", sb_q.size(), 32'd0);
    check("ovr_data", {24'b0, RX_DATA}, 32'h22);
    check("ovr_status", {31'b0, RX_STATUS}, 32'd1);
    check("ovr_overrun", {31'b0, RX_OVERRUN}, 32'd1);
    do_reset("ovr_clear");

    // Back-to-back with acknowledge exactly on the second delivery
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, 1'b1);
    check("ackd_first_status", {31'b0, RX_STATUS}, 32'd1);
    check("ackd_first_overrun", {31'b0, RX_OVERRUN}, 32'd0);
    sb_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1, -1, 1'b0);
      ack_on_delivery();
    join
    check("ackd_sb_empty", sb_q.size(), 32'd0);
    check("ackd_status", {31'b0, RX_STATUS}, 32'd1);
    check("ackd_data", {24'b0, RX_DATA}, 32'h22);
    check("ackd_overrun", {31'b0, RX_OVERRUN}, 32'd0);

    // Reset in the middle of data bit 4, then a clean frame
    wait_ticks(1);
    $display("send partial frame C3 aborted by reset");
    UART_RX = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      UART_RX = ((8'hC3 >> i) & 8'h01) != 0;
      wait_ticks(OS);
    end
    UART_RX = 1'b0;
    wait_ticks(OS / 2);
    UART_RX = 1'b1;
    do_reset("midframe");
    wait_ticks(4);
    check("midframe_no_delivery", {31'b0, RX_STATUS}, 32'd0);
    sb_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, 1'b1);
    check("r5a_sb_empty", sb_q.size(), 32'd0);
    check("r5a_latency", last_deliv_cyc - start_cyc, TICK_DIV * DELIVER_TICK);
    check("r5a_data", {24'b0, RX_DATA}, 32'h5A);
    check("r5a_status", {31'b0, RX_STATUS}, 32'd1);
    check("r5a_overrun", {31'b0, RX_OVERRUN}, 32'd0);
    ack_pulse();

`ifdef UART_RX_MAJORITY_EN
    // One-tick low spike at the centre of a high data bit is outvoted
    sb_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 0, 1'b1);
    check("spike_sb_empty", sb_q.size(), 32'd0);
    check("spike_data", {24'b0, RX_DATA}, 32'hA5);
    ack_pulse();
`endif

    check("final_ferr_count", ferr_count, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
